// File: rtl/mod107_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod107_pkg
//  Description : Shared constants and FSM state type for the mod-107 Horner
//                reduction controller and its fold sub-module.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package mod107_pkg;

    localparam int MOD        = 107;  // modulus
    localparam int CHUNK_W    = 6;    // operand chunk width
    localparam int MAX_CHUNKS = 84;   // 500-bit operand in 6-bit chunks
    localparam int RADIX      = 64;   // 2^CHUNK_W mod MOD
    localparam int FOLD_W     = 13;   // width of acc*RADIX + chunk (max 6847)
    localparam int RES_W      = 7;    // residue width
    localparam int CNT_W      = 7;    // chunk counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mod107_fold.sv
`default_nettype none
// ============================================================================
//  Module      : mod107_fold
//  Description : Combinational reduction of a 13-bit value below 6848
//                (= MOD*64) to its residue mod MOD.
//  Ports       : value   in  FOLD_W  input, must be < MOD*64
//                residue out RES_W   value mod MOD
//  Revision    : 1.0  initial release
// ============================================================================
module mod107_fold #(
    parameter int MOD = mod107_pkg::MOD
) (
    input  logic [mod107_pkg::FOLD_W-1:0] value,
    output logic [mod107_pkg::RES_W-1:0]  residue
);
    import mod107_pkg::*;

    // Because value < MOD*64 the quotient fits in 6 bits, so a restoring
    // division with conditional subtracts of MOD*32 .. MOD*1 is exact.
    logic [FOLD_W-1:0] w_rem [0:5];
    logic [FOLD_W-1:0] w_last;

    localparam logic [FOLD_W-1:0] C_MOD = FOLD_W'(MOD);

    assign w_rem[0] = value;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        localparam logic [FOLD_W-1:0] C_SUB = FOLD_W'(MOD << (5 - k));
        assign w_rem[k+1] = (w_rem[k] >= C_SUB) ? (w_rem[k] - C_SUB) : w_rem[k];
    end

    assign w_last  = (w_rem[5] >= C_MOD) ? (w_rem[5] - C_MOD) : w_rem[5];
    assign residue = RES_W'(w_last);

endmodule
`default_nettype wire

// File: rtl/mod107_horner_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mod107_horner_ctrl
//  Description : Streams an operand MS-chunk first and reduces it mod MOD by
//                Horner's rule, one chunk per cycle, using a single shared
//                fold unit.
//  Ports       : clk          in   clock
//                rst          in   synchronous active-high reset
//                start        in   begin a reduction (IDLE only)
//                num_chunks   in   chunk count, saturated to MAX_CHUNKS
//                chunk_valid  in   chunk_data valid
//                chunk_data   in   next chunk, most significant first
//                chunk_ready  out  chunk accepted this cycle when valid
//                busy         out  high in RUN and DONE
//                done         out  one-cycle pulse, residue final
//                residue      out  operand mod MOD, held until next result
//  Revision    : 1.0  initial release
// ============================================================================
module mod107_horner_ctrl #(
    parameter int MOD        = mod107_pkg::MOD,
    parameter int CHUNK_W    = mod107_pkg::CHUNK_W,
    parameter int MAX_CHUNKS = mod107_pkg::MAX_CHUNKS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [mod107_pkg::CNT_W-1:0]  num_chunks,
    input  logic                          chunk_valid,
    input  logic [CHUNK_W-1:0]            chunk_data,
    output logic                          chunk_ready,
    output logic                          busy,
    output logic                          done,
    output logic [mod107_pkg::RES_W-1:0]  residue
);
    import mod107_pkg::*;

    localparam logic [CNT_W-1:0] C_MAX_CHUNKS = CNT_W'(MAX_CHUNKS);

    state_t             r_state;
    state_t             w_state_next;
    logic [RES_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [RES_W-1:0]   r_residue;

    logic               w_run;
    logic               w_hs;
    logic               w_last;
    logic [CNT_W-1:0]   w_num_sat;
    logic [FOLD_W-1:0]  w_sum;
    logic [RES_W-1:0]   w_fold;

    assign w_run     = (r_state == ST_RUN);
    // Reset masks the handshake so a chunk offered during reset is dropped.
    assign w_hs      = w_run & chunk_valid & ~rst;
    assign w_last    = (r_count == CNT_W'(1));
    assign w_num_sat = (num_chunks > C_MAX_CHUNKS) ? C_MAX_CHUNKS : num_chunks;

    // Full-width Horner step; acc*64+chunk never exceeds 6847.
    assign w_sum = FOLD_W'(r_acc) * FOLD_W'(RADIX) + FOLD_W'(chunk_data);

    mod107_fold #(
        .MOD     (MOD)
    ) u_fold (
        .value   (w_sum),
        .residue (w_fold)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_chunks == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_hs && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        chunk_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        if (!rst) begin
            chunk_ready = w_run;
            busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
            done        = (r_state == ST_DONE);
        end
    end

    // ---------------- datapath ----------------
    // residue is loaded on the edge that enters DONE, so it equals the final
    // acc throughout the DONE cycle and is held afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_count   <= '0;
            r_residue <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_count <= w_num_sat;
                        if (num_chunks == '0) begin
                            r_residue <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        r_acc   <= w_fold;
                        r_count <= r_count - CNT_W'(1);
                        if (w_last) begin
                            r_residue <= w_fold;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign residue = r_residue;

endmodule
`default_nettype wire

// File: tb/tb_mod107_horner_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod107_horner_ctrl
//  Description : Self-checking bench for mod107_horner_ctrl. A job-level
//                model (wide operand integer, reduced with %) is compared
//                with the DUT every cycle; directed jobs add literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mod107_horner_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] num_chunks;
    logic       chunk_valid;
    logic [5:0] chunk_data;
    logic       chunk_ready;
    logic       busy;
    logic       done;
    logic [6:0] residue;

    logic [12:0] fold_in;
    logic [6:0]  fold_out;

    always #5 clk = ~clk;

    mod107_horner_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_chunks  (num_chunks),
        .chunk_valid (chunk_valid),
        .chunk_data  (chunk_data),
        .chunk_ready (chunk_ready),
        .busy        (busy),
        .done        (done),
        .residue     (residue)
    );

    mod107_fold u_fold_ref_check (
        .value   (fold_in),
        .residue (fold_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- job-level reference model ----------------
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit          mon_en     = 1'b0;
    bit          m_active   = 1'b0;  // a job is accepting chunks
    bit          m_done_due = 1'b0;  // this cycle must show the done pulse
    int          m_remaining = 0;
    logic [511:0] m_big     = '0;    // operand assembled from accepted chunks
    int          m_res      = 0;
    int          hs_cnt     = 0;
    int          done_cnt   = 0;
    int          ready_cnt  = 0;
    int          start_cyc  = 0;
    int          done_cyc   = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("done",        int'(done),        (!rst && m_done_due) ? 1 : 0);
            chk("busy",        int'(busy),        (!rst && (m_active || m_done_due)) ? 1 : 0);
            chk("chunk_ready", int'(chunk_ready), (!rst && m_active) ? 1 : 0);
            if (!rst) chk("residue", int'(residue), m_res);
            if (chunk_ready) ready_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            // advance the model by what the coming edge does
            if (rst) begin
                m_active   = 1'b0;
                m_done_due = 1'b0;
                m_res      = 0;
            end else if (m_done_due) begin
                m_done_due = 1'b0;
            end else if (m_active) begin
                if (chunk_valid) begin
                    hs_cnt++;
                    m_big = (m_big << 6) | 512'(chunk_data);
                    m_remaining--;
                    if (m_remaining == 0) begin
                        m_active   = 1'b0;
                        m_done_due = 1'b1;
                        m_res      = int'(m_big % 512'd107);
                    end
                end
            end else if (start) begin
                start_cyc   = cyc;
                m_remaining = (int'(num_chunks) > 84) ? 84 : int'(num_chunks);
                m_big       = '0;
                if (m_remaining == 0) begin
                    m_done_due = 1'b1;
                    m_res      = 0;
                end else begin
                    m_active = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start      = 1'b1;
        num_chunks = 7'(n);
        tick();
        start      = 1'b0;
        num_chunks = 7'd0;
    endtask

    task automatic send(input int data, input int gap);
        for (int g = 0; g < gap; g++) tick();
        chunk_valid = 1'b1;
        chunk_data  = 6'(data);
        tick();
        chunk_valid = 1'b0;
        chunk_data  = 6'd0;
    endtask

    task automatic wait_done(input int d0, input string name);
        for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
        if (done_cnt == d0) chk({name, "_timeout"}, 0, 1);
        tick();
    endtask

    int d0, h0, r0;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_chunks  = 7'd0;
        chunk_valid = 1'b0;
        chunk_data  = 6'd0;
        fold_in     = 13'd0;

        // exhaustive fold check against integer %
        for (int v = 0; v < 6848; v++) begin
            fold_in = 13'(v);
            #1;
            if (int'(fold_out) != v % 107) chk("fold", int'(fold_out), v % 107);
            else total++;
        end

        tick();
        mon_en = 1'b1;
        tick();
        tick();
        chk("reset_residue", int'(residue), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        tick();

        // chunks 1,0 back to back -> 64, done 3 cycles after start
        d0 = done_cnt;
        do_start(2);
        send(1, 0);
        send(0, 0);
        wait_done(d0, "t1");
        chk("t1_residue", int'(residue), 64);
        chk("t1_latency", done_cyc - start_cyc, 3);

        // 63, 3 idle cycles, 63 -> 4095 mod 107 = 29
        d0 = done_cnt;
        do_start(2);
        send(63, 0);
        send(63, 3);
        wait_done(d0, "t2");
        chk("t2_residue", int'(residue), 29);

        // 1,0,0 with a start pulse mid-job -> 30
        d0 = done_cnt;
        do_start(3);
        send(1, 0);
        start = 1'b1; num_chunks = 7'd5;
        tick();
        start = 1'b0; num_chunks = 7'd0;
        send(0, 0);
        send(0, 0);
        wait_done(d0, "t3");
        chk("t3_residue", int'(residue), 30);
        chk("t3_single_done", done_cnt - d0, 1);

        // zero chunks -> immediate done, no ready
        d0 = done_cnt;
        r0 = ready_cnt;
        do_start(0);
        wait_done(d0, "t4");
        chk("t4_residue", int'(residue), 0);
        chk("t4_latency", done_cyc - start_cyc, 1);
        chk("t4_no_ready", ready_cnt - r0, 0);

        // reset after first handshake aborts the job
        d0 = done_cnt;
        do_start(2);
        send(5, 0);
        rst = 1'b1; chunk_valid = 1'b1; chunk_data = 6'd7;
        tick();
        rst = 1'b0; chunk_valid = 1'b0; chunk_data = 6'd0;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_residue", int'(residue), 0);
        d0 = done_cnt;
        do_start(1);
        send(63, 0);
        wait_done(d0, "t5b");
        chk("t5b_residue", int'(residue), 63);

        // over-long request saturates to 84 chunks
        d0 = done_cnt;
        h0 = hs_cnt;
        do_start(100);
        chunk_valid = 1'b1;
        for (int i = 0; i < 120 && done_cnt == d0; i++) begin
            chunk_data = 6'((i * 37 + 11) % 64);
            tick();
        end
        chunk_valid = 1'b0;
        if (done_cnt == d0) chk("t6_timeout", 0, 1);
        tick();
        chk("t6_handshakes", hs_cnt - h0, 84);

        // a few gapped jobs with varied data, checked by the model
        for (int j = 0; j < 4; j++) begin
            d0 = done_cnt;
            do_start(3 + j);
            for (int k = 0; k < 3 + j; k++) send(int'($urandom_range(0, 63)), int'($urandom_range(0, 2)));
            wait_done(d0, "t7");
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
